pwm_meas: RTL
=============

# pwm_meas

Receive-side counterpart of the PWM generator: samples an asynchronous PWM input, measures high time and period in `clk` cycles, and reports the decoded 10-bit duty value with a one-cycle valid strobe. It sits on the input side of the design, for example reading back a generated PWM for self-test or decoding an external PWM command. A timeout flags a stuck input: constant high, constant low, or 0%/100% duty.

## Interface
- `CNT_W`, default 12: width of the internal cycle counter and of `period` and `high_time`.
- `TIMEOUT`, default 2047: cycles without a qualifying edge before `stuck` asserts. Must be less than 2^CNT_W − 1.
- `clk` in 1: system clock. All logic is on the rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `PWM_in` in 1: asynchronous PWM input.
- `duty` out 10: decoded duty, equal to `high_time` − 1, saturated to 0x3FF.
- `high_time` out CNT_W: cycles high in the last complete period.
- `period` out CNT_W: cycles from rising edge to rising edge.
- `vld` out 1: one-cycle pulse; the outputs above were updated on this cycle.
- `stuck` out 1: level; the input has had no edge for `TIMEOUT` cycles.
- `stuck_lvl` out 1: synchronized input level when `stuck` set.

## Operation
- **Input conditioning**
  - `PWM_in` passes through two flops, `s1` then `s2`, then a history flop `prev`.
  - `rise = s2 & ~prev`; `fall = ~s2 & prev`.
- **FSM states:** IDLE, HIGH, LOW.
- **IDLE**
  - On `rise`: `cnt`←1, go to HIGH, clear `stuck`.
  - Otherwise `cnt` increments, saturating at `TIMEOUT`.
- **HIGH**
  - On `fall`: `hi_cap`←`cnt`, `cnt`←`cnt`+1, go to LOW.
  - Otherwise `cnt`←`cnt`+1.
- **LOW**
  - On `rise`:
    - `period`←`cnt`, `high_time`←`hi_cap`, `duty`←sat10(`hi_cap`−1), `vld`←1.
    - `cnt`←1, go to HIGH.
  - Otherwise `cnt`←`cnt`+1.
- **Timeout** (HIGH or LOW, no edge this cycle, `cnt` == `TIMEOUT`)
  - `stuck`←1, `stuck_lvl`←`s2`, go to IDLE.
  - `cnt` holds at `TIMEOUT`; no `vld`.
- **IDLE stuck detection:** also asserts `stuck` when `cnt` reaches `TIMEOUT`, so a constant input after reset is flagged.
- **First measurement:** the first rising edge after reset or after `stuck` only arms the FSM. The first `vld` comes after one full period.
- **Arithmetic**
  - `cnt` is unsigned CNT_W and never wraps, because the timeout fires first.
  - `duty` = 0x3FF when `hi_cap` − 1 > 0x3FF.
  - `hi_cap` ≥ 1 always, so no underflow.
- **Output hold:** outputs hold their last values between `vld` pulses and while `stuck`.
- **Pulse resolution:** input pulses shorter than one `clk` period may be missed. Any pulse that spans one sampling edge is counted as ≥1 cycle.

## Timing
- **Reset state** (asynchronous, immediate on `rst_n` low):
  - `s1`/`s2`/`prev` = 0, FSM = IDLE, `cnt` = 0.
  - `duty`, `high_time`, `period` = 0; `vld`, `stuck`, `stuck_lvl` = 0.
- **Reset mid-measurement:** the partial period is discarded and no `vld` is issued.
- **Edge-to-`vld` latency:** the `clk` edge that first samples the new `PWM_in` level is edge k. `s2` shows the level after edge k+1. `vld` and updated outputs are visible after edge k+2 and stay for exactly one cycle.
- **Measurement accuracy:** an ideal synchronous input with period P and high time H gives `period` = P and `high_time` = H exactly.
- **Decoding the generator:** the generator's high time is duty+1 and its period is 1024, so `duty` reproduces the programmed value.
- **Simultaneous timeout and edge:** the edge wins; timeout is not taken.

## Structure
- **Package `pwm_pkg`:**
  - state enum `pwm_meas_st_t` (IDLE, HIGH, LOW);
  - constants `PWM_DUTY_W` = 10 and `PWM_PERIOD` = 1024.
- **Sub-module `pwm_in_sync`:**
  - 2-flop synchronizer plus history flop, asynchronously reset to 0;
  - outputs `lvl`, `rise`, `fall`.
  - Reusable for other asynchronous inputs.
- **`pwm_meas`:** FSM, counter, capture registers.

## Test plan
- **Generator loopback, duty 0x200:** drive `PWM_in` from the PWM generator programmed to 0x200 → after the second rising edge, `vld` pulses once per 1024 cycles with `period` = 1024, `high_time` = 0x201, `duty` = 0x200.
- **Sweep 0x000, 0x001, 0x3FE:** → `duty` equals the programmed value each period, with the first `vld` exactly 1024 cycles after the arming edge.
- **Constant high (generator duty 0x3FF):** → `stuck` = 1 and `stuck_lvl` = 1 within `TIMEOUT`+3 cycles of the last edge; no further `vld`.
- **Constant low from reset:** → `stuck` = 1 and `stuck_lvl` = 0 at cycle `TIMEOUT`+3. A later pulse train clears `stuck` on the first rise, and the first `vld` follows one period later.
- **Direct stimulus H = 3, P = 10, input changing mid-cycle:** → `high_time` = 3, `period` = 10, `duty` = 2, with `vld` two edges after `s1` samples the rise.
- **`rst_n` pulse during HIGH:** → all outputs 0 immediately and no `vld` until a full new period completes.

Source files
------------

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types and constants for the PWM measurement slice.
//   pwm_meas_st_t : measurement FSM state (idle / input high / input low)
//   PWM_DUTY_W    : width of the decoded duty value
//   PWM_PERIOD    : generator period in clk cycles
//   sat_duty()    : high time minus one, saturated to the duty width
package pwm_pkg;

    localparam int unsigned PWM_DUTY_W = 10;
    localparam int unsigned PWM_PERIOD = 1024;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StHigh = 2'd1,
        StLow  = 2'd2
    } pwm_meas_st_t;

    // High time is always >= 1 when captured, so the subtraction cannot underflow.
    function automatic logic [PWM_DUTY_W-1:0] sat_duty(input logic [31:0] hi_time);
        logic [31:0] m1;
        m1 = hi_time - 32'd1;
        if (m1 > 32'((1 << PWM_DUTY_W) - 1)) begin
            return '1;
        end
        return m1[PWM_DUTY_W-1:0];
    endfunction

endpackage

// File: rtl/pwm_in_sync.sv
// pwm_in_sync: two-flop synchronizer plus history flop for an asynchronous input.
//   clk   : sampling clock (rising edge)
//   rst_n : asynchronous active-low reset, all flops clear to 0
//   din   : asynchronous input
//   lvl   : synchronized level (second flop)
//   rise  : synchronized level went 0 -> 1 this cycle
//   fall  : synchronized level went 1 -> 0 this cycle
module pwm_in_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic r_s1;
    logic r_s2;
    logic r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_s1   <= din;
            r_s2   <= r_s1;
            r_prev <= r_s2;
        end
    end

    assign lvl  = r_s2;
    assign rise = r_s2 & ~r_prev;
    assign fall = ~r_s2 & r_prev;

endmodule

// File: rtl/pwm_meas.sv
// pwm_meas: measures high time and period of an asynchronous PWM input in clk cycles.
//   clk       : system clock (rising edge)
//   rst_n     : asynchronous active-low reset
//   PWM_in    : asynchronous PWM input
//   duty      : high_time - 1 saturated to 10 bits
//   high_time : high cycles of the last complete period
//   period    : rising-edge to rising-edge cycles of the last complete period
//   vld       : one-cycle strobe, outputs above updated this cycle
//   stuck     : no qualifying edge for TIMEOUT cycles
//   stuck_lvl : synchronized input level captured when stuck was set
module pwm_meas
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_W   = 12,
    parameter int unsigned TIMEOUT = 2047
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  PWM_in,
    output logic [PWM_DUTY_W-1:0] duty,
    output logic [CNT_W-1:0]      high_time,
    output logic [CNT_W-1:0]      period,
    output logic                  vld,
    output logic                  stuck,
    output logic                  stuck_lvl
);

    localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    logic w_lvl;
    logic w_rise;
    logic w_fall;

    pwm_in_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (PWM_in),
        .lvl   (w_lvl),
        .rise  (w_rise),
        .fall  (w_fall)
    );

    pwm_meas_st_t r_state;
    pwm_meas_st_t w_state_nxt;

    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      r_hi_cap;
    logic [CNT_W-1:0]      r_period;
    logic [CNT_W-1:0]      r_high_time;
    logic [PWM_DUTY_W-1:0] r_duty;
    logic                  r_vld;
    logic                  r_stuck;
    logic                  r_stuck_lvl;

    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_cap_hi;
    logic             w_meas_done;
    logic             w_set_stuck;
    logic             w_clr_stuck;
    logic             w_timeout;

    // >= rather than == keeps the counter bounded even if a fall lands exactly on TIMEOUT.
    assign w_timeout = (r_cnt >= TO_CNT);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; an edge always wins over a coincident timeout.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_rise) begin
                    w_state_nxt = StHigh;
                end
            end
            StHigh: begin
                if (w_fall) begin
                    w_state_nxt = StLow;
                end else if (w_timeout) begin
                    w_state_nxt = StIdle;
                end
            end
            StLow: begin
                if (w_rise) begin
                    w_state_nxt = StHigh;
                end else if (w_timeout) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // Per-state actions for the counter, captures and status flags.
    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_cap_hi    = 1'b0;
        w_meas_done = 1'b0;
        w_set_stuck = 1'b0;
        w_clr_stuck = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_rise) begin
                    // Arming edge only: the period that starts here is measured next.
                    w_cnt_nxt   = ONE;
                    w_clr_stuck = 1'b1;
                end else begin
                    w_cnt_nxt = w_timeout ? TO_CNT : r_cnt + ONE;
                    // Catches an input that never toggles after reset.
                    if (w_timeout && !r_stuck) begin
                        w_set_stuck = 1'b1;
                    end
                end
            end
            StHigh: begin
                if (w_fall) begin
                    w_cap_hi  = 1'b1;
                    w_cnt_nxt = r_cnt + ONE;
                end else if (w_timeout) begin
                    w_set_stuck = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + ONE;
                end
            end
            StLow: begin
                if (w_rise) begin
                    w_meas_done = 1'b1;
                    w_cnt_nxt   = ONE;
                end else if (w_timeout) begin
                    w_set_stuck = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + ONE;
                end
            end
            default: begin
                w_cnt_nxt = '0;
            end
        endcase
    end

    // Counter, capture and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_hi_cap    <= '0;
            r_period    <= '0;
            r_high_time <= '0;
            r_duty      <= '0;
            r_vld       <= 1'b0;
            r_stuck     <= 1'b0;
            r_stuck_lvl <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_vld <= w_meas_done;
            if (w_cap_hi) begin
                r_hi_cap <= r_cnt;
            end
            if (w_meas_done) begin
                r_period    <= r_cnt;
                r_high_time <= r_hi_cap;
                r_duty      <= sat_duty(32'(r_hi_cap));
            end
            if (w_set_stuck) begin
                r_stuck     <= 1'b1;
                r_stuck_lvl <= w_lvl;
            end else if (w_clr_stuck) begin
                r_stuck <= 1'b0;
            end
        end
    end

    assign duty      = r_duty;
    assign high_time = r_high_time;
    assign period    = r_period;
    assign vld       = r_vld;
    assign stuck     = r_stuck;
    assign stuck_lvl = r_stuck_lvl;

endmodule
